i2c_cmd_sequencer: RTL and testbench

I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

---
 rtl/i2c_cmd_sequencer.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_sequencer.sv
// Purpose : MMIO-programmed command sequencer that feeds an I2C byte master from a command FIFO and collects read bytes.
// Latency : a push into an empty command FIFO raises wr_i2c 2 cycles later; rd_data is registered (1 cycle after the read strobe).
// Backpres: the master's ready gates acceptance; a push to a full FIFO or a read byte for a full receive FIFO is dropped and flags overflow.
//
// Ports:
//   clk, arst_n                  clock, synchronous active-low reset
//   cs, write, read, addr        single-cycle MMIO strobes and register select
//   wr_data / rd_data            MMIO write data / registered read data
//   cmd, din, slave_addr, dvsr   command, data byte, address byte and divisor to the master
//   en_ack, wr_i2c               master ACKs read bytes / command valid
//   tx_empty, rx_full            command FIFO empty / receive FIFO full
//   ready, done_tick, ack, dout  master status and received byte
//
// Build option: define I2C_SEQ_NACK_ABORT_EN to flush queued commands and issue a STOP on a NACKed write.

// Generic FIFO: fixed-depth ring buffer, combinational head.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; flush empties it.
module i2c_seq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      flush,
    input  logic                      push_vld,
    input  logic [W-1:0]              push_dat,
    input  logic                      pop_rdy,
    output logic [W-1:0]              head_dat,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push_vld && !full;
    assign do_pop   = pop_rdy && !empty;
    assign head_dat = mem[rd_ptr];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!arst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module i2c_cmd_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int RX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        cs,
    input  logic        write,
    input  logic        read,
    input  logic [1:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic [2:0]  cmd,
    output logic [7:0]  din,
    output logic [7:0]  slave_addr,
    output logic [15:0] dvsr,
    output logic        en_ack,
    output logic        wr_i2c,
    output logic        tx_empty,
    output logic        rx_full,
    input  logic        ready,
    input  logic        done_tick,
    input  logic        ack,
    input  logic [7:0]  dout
);
    localparam logic [2:0] CMD_START   = 3'd0;
    localparam logic [2:0] CMD_WR      = 3'd1;
    localparam logic [2:0] CMD_RD      = 3'd2;
    localparam logic [2:0] CMD_STOP    = 3'd3;
    localparam logic [2:0] CMD_RESTART = 3'd4;
    localparam logic [2:0] CMD_NOP     = 3'd7;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    localparam int CCW = $clog2(CMD_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;

    logic [1:0]     state;
    logic [2:0]     cur_cmd;
    logic           mmio_wr, mmio_rd;
    logic           cmd_push, cmd_pop, cmd_flush, cmd_drop;
    logic [10:0]    cmd_head;
    logic           cmd_full, cmd_empty;
    logic [CCW-1:0] cmd_count;
    logic           rx_push, rx_pop, rx_drop;
    logic [7:0]     rx_head;
    logic           rx_full_i, rx_empty;
    logic [RCW-1:0] rx_count;
    logic           issue_skip, accept, done_evt, nack_set;
    logic           stop_pend;
    logic           nack_err, overflow, busy, err_clr;
    logic [31:0]    status;
    logic           unused_bits;

    assign unused_bits = ^{wr_data[30:16], CMD_START, CMD_RESTART};

    assign mmio_wr  = cs && write;
    assign mmio_rd  = cs && read;
    assign cmd_push = mmio_wr && (addr == 2'd0);
    assign cmd_drop = cmd_push && cmd_full;
    assign rx_pop   = mmio_rd && (addr == 2'd1);
    assign err_clr  = mmio_wr && (addr == 2'd3) && wr_data[31];

    i2c_seq_fifo #(.W(11), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk      (clk),
        .arst_n   (arst_n),
        .flush    (cmd_flush),
        .push_vld (cmd_push),
        .push_dat (wr_data[10:0]),
        .pop_rdy  (cmd_pop),
        .head_dat (cmd_head),
        .full     (cmd_full),
        .empty    (cmd_empty),
        .count    (cmd_count)
    );

    i2c_seq_fifo #(.W(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .arst_n   (arst_n),
        .flush    (1'b0),
        .push_vld (rx_push),
        .push_dat (dout),
        .pop_rdy  (rx_pop),
        .head_dat (rx_head),
        .full     (rx_full_i),
        .empty    (rx_empty),
        .count    (rx_count)
    );

    assign tx_empty = cmd_empty;
    assign rx_full  = rx_full_i;

    // A pending abort STOP overrides whatever sits at the FIFO head.
    always_comb begin
        cmd = CMD_NOP;
        din = 8'h00;
        if (stop_pend) begin
            cmd = CMD_STOP;
        end else if (!cmd_empty) begin
            cmd = cmd_head[10:8];
            din = cmd_head[7:0];
        end
    end

    // NO_OP (or a FIFO emptied under us) is consumed silently without bothering the master.
    assign issue_skip = (state == ST_ISSUE) && !stop_pend && (cmd == CMD_NOP);
    assign wr_i2c     = (state == ST_ISSUE) && !issue_skip;
    assign accept     = wr_i2c && ready;
    assign cmd_pop    = (state == ST_ISSUE) && !stop_pend && (accept || issue_skip);

    assign done_evt = (state == ST_WAIT_DONE) && done_tick;
    assign rx_push  = done_evt && (cur_cmd == CMD_RD);
    assign rx_drop  = rx_push && rx_full_i;
    // ack high after a written byte means the slave NACKed it.
    assign nack_set = done_evt && (cur_cmd == CMD_WR) && ack;

`ifdef I2C_SEQ_NACK_ABORT_EN
    assign cmd_flush = nack_set;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            stop_pend <= 1'b0;
        end else if (nack_set) begin
            stop_pend <= 1'b1;
        end else if (accept) begin
            stop_pend <= 1'b0;
        end
    end
`else
    assign cmd_flush = 1'b0;
    assign stop_pend = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state   <= ST_IDLE;
            cur_cmd <= CMD_NOP;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!cmd_empty) state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (issue_skip) begin
                        state <= ST_IDLE;
                    end else if (ready) begin
                        cur_cmd <= cmd;
                        state   <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    // Master drops ready once it has started the command.
                    if (!ready) begin
                        state <= ((cur_cmd == CMD_WR) || (cur_cmd == CMD_RD)) ? ST_WAIT_DONE : ST_IDLE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (done_tick) state <= cmd_flush ? ST_ISSUE : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Error flags: a set in the same cycle as a clear wins so no event is lost.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            nack_err <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (err_clr) begin
                nack_err <= 1'b0;
                overflow <= 1'b0;
            end
            if (nack_set)            nack_err <= 1'b1;
            if (cmd_drop || rx_drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            dvsr       <= 16'h0000;
            slave_addr <= 8'h00;
            en_ack     <= 1'b0;
        end else if (mmio_wr) begin
            if (addr == 2'd2) dvsr <= wr_data[15:0];
            if (addr == 2'd3) begin
                en_ack     <= wr_data[8];
                slave_addr <= wr_data[7:0];
            end
        end
    end

    assign busy   = (state != ST_IDLE) || !cmd_empty;
    assign status = {8'(rx_count), 8'(cmd_count), 11'b0, overflow, busy, nack_err, rx_empty, cmd_full};

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            rd_data <= 32'h0;
        end else if (mmio_rd) begin
            case (addr)
                2'd0:    rd_data <= status;
                2'd1:    rd_data <= rx_empty ? 32'h0 : {24'h0, rx_head};
                2'd2:    rd_data <= {16'h0, dvsr};
                default: rd_data <= {23'h0, en_ack, slave_addr};
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
module tb_i2c_cmd_sequencer;
    logic        clk;
    logic        arst_n;
    logic        cs, write, read;
    logic [1:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [2:0]  cmd;
    logic [7:0]  din;
    logic [7:0]  slave_addr;
    logic [15:0] dvsr;
    logic        en_ack, wr_i2c, tx_empty, rx_full;
    logic        ready, done_tick, ack;
    logic [7:0]  dout;

    int n_cmp = 0;
    int n_bad = 0;

    // master model controls and observation log
    logic       mst_hold = 1'b0;
    int         mst_delay = 3;
    logic [2:0] log_cmd[$];
    logic [7:0] log_din[$];
    logic [7:0] rd_src[$];
    logic       ack_src[$];

    logic [31:0] rv;

    i2c_cmd_sequencer #(.CMD_DEPTH(4), .RX_DEPTH(4)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .cs         (cs),
        .write      (write),
        .read       (read),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .cmd        (cmd),
        .din        (din),
        .slave_addr (slave_addr),
        .dvsr       (dvsr),
        .en_ack     (en_ack),
        .wr_i2c     (wr_i2c),
        .tx_empty   (tx_empty),
        .rx_full    (rx_full),
        .ready      (ready),
        .done_tick  (done_tick),
        .ack        (ack),
        .dout       (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic mmio_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic mmio_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; read = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; read = 1'b0;
        d = rd_data;
    endtask

    task automatic wait_log(input int n);
        for (int i = 0; i < 400 && log_cmd.size() < n; i++) @(negedge clk);
        repeat (14) @(negedge clk);
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [2:0] ec,
                           input logic [7:0] ed, input logic use_din);
        logic [31:0] o;
        logic [31:0] e;
        o = 32'hxxxx_xxxx;
        if (idx < log_cmd.size()) o = use_din ? {21'h0, log_cmd[idx], log_din[idx]} : {29'h0, log_cmd[idx]};
        e = use_din ? {21'h0, ec, ed} : {29'h0, ec};
        chk(tag, o, e);
    endtask

    task automatic clear_logs();
        log_cmd.delete(); log_din.delete(); rd_src.delete(); ack_src.delete();
    endtask

    // I2C byte-master model: accepts when ready&&wr_i2c, drops ready, finishes after mst_delay cycles.
    initial begin
        logic       m_pend;
        int         m_cnt;
        logic [2:0] m_cur;
        m_pend = 1'b0; m_cnt = 0; m_cur = 3'd7;
        ready = 1'b1; done_tick = 1'b0; ack = 1'b0; dout = 8'h00;
        forever begin
            @(negedge clk);
            done_tick = 1'b0;
            if (!arst_n) begin
                m_pend = 1'b0; m_cnt = 0; ready = 1'b1;
            end else begin
                if (m_pend) begin
                    m_pend = 1'b0; ready = 1'b0; m_cnt = mst_delay;
                end else if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        ready = !mst_hold;
                        if (m_cur == 3'd2) begin
                            dout = 8'h00;
                            if (rd_src.size() > 0) dout = rd_src.pop_front();
                            done_tick = 1'b1;
                        end else if (m_cur == 3'd1) begin
                            ack = 1'b0;
                            if (ack_src.size() > 0) ack = ack_src.pop_front();
                            done_tick = 1'b1;
                        end
                    end
                end else begin
                    ready = !mst_hold;
                end
                if (ready && wr_i2c) begin
                    log_cmd.push_back(cmd);
                    log_din.push_back(din);
                    m_cur  = cmd;
                    m_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        arst_n = 1'b0; cs = 1'b0; write = 1'b0; read = 1'b0; addr = 2'd0; wr_data = 32'h0;

        // ---- reset state
        repeat (3) @(negedge clk);
        chk("rst wr_i2c", 32'(wr_i2c), 32'h0);
        chk("rst tx_empty", 32'(tx_empty), 32'h1);
        chk("rst rx_full", 32'(rx_full), 32'h0);
        chk("rst rd_data", rd_data, 32'h0);
        chk("rst dvsr", 32'(dvsr), 32'h0);
        chk("rst slave_addr/en_ack", {23'h0, en_ack, slave_addr}, 32'h0);
        chk("rst cmd", 32'(cmd), 32'h7);
        arst_n = 1'b1;
        mmio_read(2'd0, rv);
        chk("rst status", rv, 32'h0000_0002);

        // ---- configuration registers
        mmio_write(2'd2, 32'h0000_1234);
        chk("dvsr out", 32'(dvsr), 32'h1234);
        mmio_read(2'd2, rv);
        chk("dvsr read", rv, 32'h0000_1234);
        mmio_write(2'd3, 32'h0000_01A5);
        chk("addr3 outs", {23'h0, en_ack, slave_addr}, 32'h0000_01A5);
        mmio_read(2'd3, rv);
        chk("addr3 read", rv, 32'h0000_01A5);

        // ---- START, WR A5, STOP; push-to-wr_i2c latency
        clear_logs();
        mst_hold = 1'b1;
        mmio_write(2'd0, 32'h0000_0000);
        chk("lat cycle1 wr_i2c", 32'(wr_i2c), 32'h0);
        @(negedge clk);
        chk("lat cycle2 wr_i2c", 32'(wr_i2c), 32'h1);
        chk("lat cycle2 cmd", 32'(cmd), 32'h0);
        mmio_write(2'd0, 32'h0000_01A5);
        mmio_write(2'd0, 32'h0000_0300);
        mst_hold = 1'b0;
        wait_log(3);
        chk("wr seq count", 32'(log_cmd.size()), 32'd3);
        chk_log("wr seq 0 START", 0, 3'd0, 8'h00, 1'b0);
        chk_log("wr seq 1 WR", 1, 3'd1, 8'hA5, 1'b1);
        chk_log("wr seq 2 STOP", 2, 3'd3, 8'h00, 1'b0);
        mmio_read(2'd0, rv);
        chk("wr seq status", rv, 32'h0000_0002);

        // ---- five pushes into depth-4 FIFO while master not ready
        clear_logs();
        mst_hold = 1'b1;
        mmio_write(2'd0, 32'h0000_0000);
        mmio_write(2'd0, 32'h0000_0101);
        mmio_write(2'd0, 32'h0000_0102);
        mmio_write(2'd0, 32'h0000_0103);
        mmio_write(2'd0, 32'h0000_0104);
        mmio_read(2'd0, rv);
        chk("ovf status", rv, 32'h0004_001B);
        mst_hold = 1'b0;
        wait_log(4);
        chk("ovf issued count", 32'(log_cmd.size()), 32'd4);
        chk_log("ovf 0 START", 0, 3'd0, 8'h00, 1'b0);
        chk_log("ovf 1 WR", 1, 3'd1, 8'h01, 1'b1);
        chk_log("ovf 2 WR", 2, 3'd1, 8'h02, 1'b1);
        chk_log("ovf 3 WR", 3, 3'd1, 8'h03, 1'b1);
        mmio_read(2'd0, rv);
        chk("ovf status after", rv, 32'h0000_0012);
        mmio_write(2'd3, 32'h8000_01A5);
        mmio_read(2'd0, rv);
        chk("ovf cleared", rv, 32'h0000_0002);

        // ---- START, RD, RD, STOP; read back bytes
        clear_logs();
        rd_src.push_back(8'h3C);
        rd_src.push_back(8'hC3);
        mst_hold = 1'b1;
        mmio_write(2'd0, 32'h0000_0000);
        mmio_write(2'd0, 32'h0000_0200);
        mmio_write(2'd0, 32'h0000_0200);
        mmio_write(2'd0, 32'h0000_0300);
        mst_hold = 1'b0;
        wait_log(4);
        mmio_read(2'd0, rv);
        chk("rd status", rv, 32'h0200_0000);
        mmio_read(2'd1, rv);
        chk("rd byte0", rv, 32'h0000_003C);
        mmio_read(2'd1, rv);
        chk("rd byte1", rv, 32'h0000_00C3);
        mmio_read(2'd1, rv);
        chk("rd empty", rv, 32'h0000_0000);
        mmio_read(2'd0, rv);
        chk("rd status empty", rv, 32'h0000_0002);

        // ---- receive FIFO full, fifth byte lost
        clear_logs();
        for (int i = 0; i < 4; i++) rd_src.push_back(8'(8'h10 + i));
        mst_hold = 1'b1;
        for (int i = 0; i < 4; i++) mmio_write(2'd0, 32'h0000_0200);
        mst_hold = 1'b0;
        wait_log(4);
        chk("rxfull flag", 32'(rx_full), 32'h1);
        mmio_read(2'd0, rv);
        chk("rxfull status", rv, 32'h0400_0000);
        clear_logs();
        rd_src.push_back(8'h99);
        mmio_write(2'd0, 32'h0000_0200);
        wait_log(1);
        mmio_read(2'd0, rv);
        chk("rxfull drop status", rv, 32'h0400_0010);
        for (int i = 0; i < 4; i++) begin
            mmio_read(2'd1, rv);
            chk("rxfull contents", rv, 32'(8'h10 + i));
        end
        chk("rxfull flag after drain", 32'(rx_full), 32'h0);
        mmio_write(2'd3, 32'h8000_01A5);

        // ---- NACKed write
        clear_logs();
        ack_src.push_back(1'b1);
        ack_src.push_back(1'b0);
        mst_hold = 1'b1;
        mmio_write(2'd0, 32'h0000_0000);
        mmio_write(2'd0, 32'h0000_0111);
        mmio_write(2'd0, 32'h0000_0122);
        mmio_write(2'd0, 32'h0000_0300);
        mst_hold = 1'b0;
`ifdef I2C_SEQ_NACK_ABORT_EN
        wait_log(3);
        chk("nack abort count", 32'(log_cmd.size()), 32'd3);
        chk_log("nack abort 0 START", 0, 3'd0, 8'h00, 1'b0);
        chk_log("nack abort 1 WR", 1, 3'd1, 8'h11, 1'b1);
        chk_log("nack abort 2 STOP", 2, 3'd3, 8'h00, 1'b0);
`else
        wait_log(4);
        chk("nack count", 32'(log_cmd.size()), 32'd4);
        chk_log("nack 0 START", 0, 3'd0, 8'h00, 1'b0);
        chk_log("nack 1 WR", 1, 3'd1, 8'h11, 1'b1);
        chk_log("nack 2 WR", 2, 3'd1, 8'h22, 1'b1);
        chk_log("nack 3 STOP", 3, 3'd3, 8'h00, 1'b0);
`endif
        mmio_read(2'd0, rv);
        chk("nack status", rv, 32'h0000_0006);
        mmio_write(2'd3, 32'h8000_01A5);
        mmio_read(2'd0, rv);
        chk("nack cleared", rv, 32'h0000_0002);

        // ---- reset while waiting for a read to complete, 3 entries queued
        clear_logs();
        mst_delay = 20;
        mst_hold = 1'b1;
        mmio_write(2'd0, 32'h0000_0200);
        mmio_write(2'd0, 32'h0000_0000);
        mmio_write(2'd0, 32'h0000_0155);
        mmio_write(2'd0, 32'h0000_0300);
        mst_hold = 1'b0;
        for (int i = 0; i < 50 && log_cmd.size() < 1; i++) @(negedge clk);
        mst_hold = 1'b1;
        repeat (3) @(negedge clk);
        mmio_read(2'd0, rv);
        chk("mid-xfer status", rv, 32'h0003_000A);
        arst_n = 1'b0;
        @(negedge clk);
        chk("mid rst wr_i2c", 32'(wr_i2c), 32'h0);
        chk("mid rst tx_empty", 32'(tx_empty), 32'h1);
        chk("mid rst cmd", 32'(cmd), 32'h7);
        chk("mid rst dvsr", 32'(dvsr), 32'h0);
        arst_n = 1'b1;
        mst_hold = 1'b0;
        mst_delay = 3;
        mmio_read(2'd0, rv);
        chk("mid rst status", rv, 32'h0000_0002);
        repeat (30) @(negedge clk);
        chk("mid rst nothing issued", 32'(log_cmd.size()), 32'd1);
        mmio_read(2'd0, rv);
        chk("mid rst status later", rv, 32'h0000_0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
